ristretto_exe_lsu: RTL and testbench

RISTRETTO_EXE_LSU -- requirements
Module: ristretto_exe_lsu

---
 rtl/ristretto_exe_lsu.sv | 194 +++++++++++++++++++
 tb/tb_ristretto_exe_lsu.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ristretto_exe_lsu.sv
// ---------------------------------------------------------------------------
// ristretto_exe_lsu
// Load/store unit between the execute stage and a word-wide data memory.
// Handles one access per enable level. It aligns store data and byte enables,
// extends load results, and flags misaligned accesses and bus errors.
//
// Ports
//   clk_i, rstn_i        clock, asynchronous active-low reset
//   lsu_en_i             start request (level; one access per high level)
//   lsu_op_i             0 = load, 1 = store
//   lsu_op_size_i        00 byte, 01 half, 1x word
//   lsu_unsigned_i       zero-extend loads when 1
//   lsu_addr_i           effective byte address
//   lsu_wdata_i          right-aligned store data
//   lsu_busy_o           high while in REQ, WAIT or MISAL
//   lsu_rdata_o          registered, extended load result
//   lsu_misaligned_o     high for the single MISAL cycle
//   lsu_fault_o          one-cycle pulse after an errored response
//   dmem_*               request/grant/response data-memory port
// ---------------------------------------------------------------------------
module ristretto_exe_lsu #(
   parameter int DataWidth = 32,
   parameter int AddrWidth = 32
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic                 lsu_en_i,
   input  logic                 lsu_op_i,
   input  logic [1:0]           lsu_op_size_i,
   input  logic                 lsu_unsigned_i,
   input  logic [AddrWidth-1:0] lsu_addr_i,
   input  logic [DataWidth-1:0] lsu_wdata_i,
   output logic                 lsu_busy_o,
   output logic [DataWidth-1:0] lsu_rdata_o,
   output logic                 lsu_misaligned_o,
   output logic                 lsu_fault_o,
   output logic                 dmem_req_o,
   output logic                 dmem_we_o,
   output logic [3:0]           dmem_be_o,
   output logic [AddrWidth-1:0] dmem_addr_o,
   output logic [DataWidth-1:0] dmem_wdata_o,
   input  logic                 dmem_gnt_i,
   input  logic                 dmem_rvalid_i,
   input  logic [DataWidth-1:0] dmem_rdata_i,
   input  logic                 dmem_err_i
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_REQ   = 2'b01,
      ST_WAIT  = 2'b10,
      ST_MISAL = 2'b11
   } state_e;

   state_e                 state_r, state_s;
   logic                   armed_r;
   logic                   accept_s;
   logic                   misal_s;
   logic                   op_r;
   logic [1:0]             size_r;
   logic                   uns_r;
   logic [1:0]             lane_r;
   logic [3:0]             be_r, be_s;
   logic [AddrWidth-1:0]   addr_r;
   logic [DataWidth-1:0]   wdata_r, wdata_s;
   logic [DataWidth-1:0]   rdata_r;
   logic                   fault_r;

   // Pick the addressed lane of a response word and sign/zero extend it.
   function automatic logic [31:0] load_extend(input logic [31:0] raw,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lane,
                                               input logic        uns);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] res;
      case (lane)
         2'b00:   b = raw[7:0];
         2'b01:   b = raw[15:8];
         2'b10:   b = raw[23:16];
         2'b11:   b = raw[31:24];
         default: b = raw[7:0];
      endcase
      h = lane[1] ? raw[31:16] : raw[15:0];
      case (size)
         2'b00:   res = uns ? {24'h000000, b} : {{24{b[7]}}, b};
         2'b01:   res = uns ? {16'h0000, h} : {{16{h[15]}}, h};
         default: res = raw;
      endcase
      return res;
   endfunction

   // Misalignment check, byte-enable mask and store-data replication for the incoming request.
   always_comb begin
      misal_s = 1'b0;
      be_s    = 4'b1111;
      wdata_s = lsu_wdata_i;
      case (lsu_op_size_i)
         2'b00: begin
            be_s    = 4'b0001 << lsu_addr_i[1:0];
            wdata_s = {4{lsu_wdata_i[7:0]}};
         end
         2'b01: begin
            misal_s = lsu_addr_i[0];
            be_s    = 4'b0011 << lsu_addr_i[1:0];
            wdata_s = {2{lsu_wdata_i[15:0]}};
         end
         default: begin
            misal_s = (lsu_addr_i[1:0] != 2'b00);
            be_s    = 4'b1111;
            wdata_s = lsu_wdata_i;
         end
      endcase
   end

   // Next-state logic; an accept only happens from IDLE with the enable re-armed.
   always_comb begin
      state_s  = state_r;
      accept_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (lsu_en_i && armed_r) begin
               accept_s = 1'b1;
               state_s  = misal_s ? ST_MISAL : ST_REQ;
            end else begin
               state_s  = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (dmem_gnt_i) begin
               state_s = ST_WAIT;
            end else begin
               state_s = ST_REQ;
            end
         end
         ST_WAIT: begin
            if (dmem_rvalid_i) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_WAIT;
            end
         end
         ST_MISAL: state_s = ST_IDLE;
         default:  state_s = ST_IDLE;
      endcase
   end

   // State register, request latches, load result and fault pulse.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_r <= ST_IDLE;
         armed_r <= 1'b0;
         op_r    <= 1'b0;
         size_r  <= 2'b00;
         uns_r   <= 1'b0;
         lane_r  <= 2'b00;
         be_r    <= 4'b0000;
         addr_r  <= '0;
         wdata_r <= '0;
         rdata_r <= '0;
         fault_r <= 1'b0;
      end else begin
         state_r <= state_s;
         // Accept consumes the armed flag; any sampled low enable re-arms it.
         if (accept_s) begin
            armed_r <= 1'b0;
            op_r    <= lsu_op_i;
            size_r  <= lsu_op_size_i;
            uns_r   <= lsu_unsigned_i;
            lane_r  <= lsu_addr_i[1:0];
            be_r    <= be_s;
            addr_r  <= {lsu_addr_i[AddrWidth-1:2], 2'b00};
            wdata_r <= wdata_s;
         end else if (!lsu_en_i) begin
            armed_r <= 1'b1;
         end
         if ((state_r == ST_WAIT) && dmem_rvalid_i && !dmem_err_i && !op_r) begin
            rdata_r <= load_extend(dmem_rdata_i, size_r, lane_r, uns_r);
         end
         fault_r <= (state_r == ST_WAIT) && dmem_rvalid_i && dmem_err_i;
      end
   end

   assign lsu_busy_o       = (state_r != ST_IDLE);
   assign lsu_misaligned_o = (state_r == ST_MISAL);
   assign lsu_fault_o      = fault_r;
   assign lsu_rdata_o      = rdata_r;
   assign dmem_req_o       = (state_r == ST_REQ);
   assign dmem_we_o        = op_r;
   assign dmem_be_o        = be_r;
   assign dmem_addr_o      = addr_r;
   assign dmem_wdata_o     = wdata_r;

endmodule

// File: tb/tb_ristretto_exe_lsu.sv
// ---------------------------------------------------------------------------
// tb_ristretto_exe_lsu
// Directed self-checking bench for ristretto_exe_lsu. Inputs change and
// outputs are observed on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_ristretto_exe_lsu;

   logic        clk, rstn;
   logic        lsu_en, lsu_op, lsu_uns;
   logic [1:0]  lsu_size;
   logic [31:0] lsu_addr, lsu_wdata;
   logic        busy, misal, fault;
   logic [31:0] rdata_o;
   logic        req, we;
   logic [3:0]  be;
   logic [31:0] daddr, dwdata;
   logic        gnt, rvalid, err;
   logic [31:0] drdata;

   int n_cmp = 0;
   int n_err = 0;

   ristretto_exe_lsu #(.DataWidth(32), .AddrWidth(32)) dut (
      .clk_i            (clk),
      .rstn_i           (rstn),
      .lsu_en_i         (lsu_en),
      .lsu_op_i         (lsu_op),
      .lsu_op_size_i    (lsu_size),
      .lsu_unsigned_i   (lsu_uns),
      .lsu_addr_i       (lsu_addr),
      .lsu_wdata_i      (lsu_wdata),
      .lsu_busy_o       (busy),
      .lsu_rdata_o      (rdata_o),
      .lsu_misaligned_o (misal),
      .lsu_fault_o      (fault),
      .dmem_req_o       (req),
      .dmem_we_o        (we),
      .dmem_be_o        (be),
      .dmem_addr_o      (daddr),
      .dmem_wdata_o     (dwdata),
      .dmem_gnt_i       (gnt),
      .dmem_rvalid_i    (rvalid),
      .dmem_rdata_i     (drdata),
      .dmem_err_i       (err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic test_reset();
      #3;
      n_cmp++;
      if ({busy, misal, fault, req, we} !== 5'b00000) begin
         $display("FAIL reset_ctrl got %b want 00000", {busy, misal, fault, req, we});
         n_err++;
      end
      n_cmp++;
      if ({be, daddr, dwdata, rdata_o} !== 100'd0) begin
         $display("FAIL reset_data be=%h addr=%h wdata=%h rdata=%h want all 0", be, daddr, dwdata, rdata_o);
         n_err++;
      end
      lsu_en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0) begin
         $display("FAIL reset_hold_busy got %b want 0", busy);
         n_err++;
      end
      lsu_en = 1'b0;
      rstn   = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_byte_load();
      @(negedge clk);
      lsu_en = 1'b1; lsu_op = 1'b0; lsu_size = 2'b00; lsu_uns = 1'b0;
      lsu_addr = 32'h0000_1003; gnt = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({busy, req, we, be, daddr} !== {1'b1, 1'b1, 1'b0, 4'b1000, 32'h0000_1000}) begin
         $display("FAIL byte_load_req busy=%b req=%b we=%b be=%b addr=%h want 1 1 0 1000 00001000",
                  busy, req, we, be, daddr);
         n_err++;
      end
      lsu_en = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({busy, req} !== 2'b10) begin
         $display("FAIL byte_load_wait busy/req got %b want 10", {busy, req});
         n_err++;
      end
      gnt = 1'b0; rvalid = 1'b1; drdata = 32'h80AA_BBCC;
      @(negedge clk);
      rvalid = 1'b0;
      n_cmp++;
      if ({busy, rdata_o} !== {1'b0, 32'hFFFF_FF80}) begin
         $display("FAIL byte_load_result busy=%b rdata=%h want 0 ffffff80", busy, rdata_o);
         n_err++;
      end
   endtask

   task automatic test_half_store();
      @(negedge clk);
      lsu_en = 1'b1; lsu_op = 1'b1; lsu_size = 2'b01; lsu_uns = 1'b0;
      lsu_addr = 32'h0000_2002; lsu_wdata = 32'h1234_ABCD; gnt = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         // Changing inputs while busy must not disturb the latched request.
         lsu_en = 1'b0; lsu_op = 1'b0; lsu_addr = 32'hFFFF_FFFF; lsu_wdata = 32'h0;
         n_cmp++;
         if ({busy, req, we, be, daddr, dwdata} !==
             {1'b1, 1'b1, 1'b1, 4'b1100, 32'h0000_2000, 32'hABCD_ABCD}) begin
            $display("FAIL half_store_req[%0d] busy=%b req=%b we=%b be=%b addr=%h wdata=%h",
                     i, busy, req, we, be, daddr, dwdata);
            n_err++;
         end
         if (i == 3) gnt = 1'b1;
      end
      @(negedge clk);
      n_cmp++;
      if ({busy, req} !== 2'b10) begin
         $display("FAIL half_store_wait busy/req got %b want 10", {busy, req});
         n_err++;
      end
      gnt = 1'b0; rvalid = 1'b1; drdata = 32'h5555_5555;
      @(negedge clk);
      rvalid = 1'b0;
      n_cmp++;
      if ({busy, rdata_o} !== {1'b0, 32'hFFFF_FF80}) begin
         $display("FAIL half_store_done busy=%b rdata=%h want 0 ffffff80", busy, rdata_o);
         n_err++;
      end
   endtask

   task automatic test_misaligned();
      @(negedge clk);
      lsu_en = 1'b1; lsu_op = 1'b0; lsu_size = 2'b10; lsu_addr = 32'h0000_3001; gnt = 1'b1;
      @(negedge clk);
      lsu_en = 1'b0;
      n_cmp++;
      if ({misal, busy, req} !== 3'b110) begin
         $display("FAIL misal_active misal/busy/req got %b want 110", {misal, busy, req});
         n_err++;
      end
      @(negedge clk);
      gnt = 1'b0;
      n_cmp++;
      if ({misal, busy, req, rdata_o} !== {3'b000, 32'hFFFF_FF80}) begin
         $display("FAIL misal_end misal/busy/req=%b rdata=%h want 000 ffffff80",
                  {misal, busy, req}, rdata_o);
         n_err++;
      end
   endtask

   task automatic test_loads();
      logic [1:0]  t_size  [7];
      logic        t_uns   [7];
      logic [31:0] t_addr  [7];
      logic [31:0] t_raw   [7];
      logic [3:0]  t_be    [7];
      logic [31:0] t_daddr [7];
      logic [31:0] t_exp   [7];
      t_size  = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b11};
      t_uns   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      t_addr  = '{32'h0000_1003, 32'h0000_0001, 32'h0000_0002, 32'h0000_0000,
                  32'h0000_0002, 32'h0000_0004, 32'h0000_0008};
      t_raw   = '{32'h80AA_BBCC, 32'h1122_F344, 32'h1185_F344, 32'h0000_8001,
                  32'h9ABC_1234, 32'hDEAD_BEEF, 32'hCAFE_F00D};
      t_be    = '{4'b1000, 4'b0010, 4'b0100, 4'b0011, 4'b1100, 4'b1111, 4'b1111};
      t_daddr = '{32'h0000_1000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
                  32'h0000_0000, 32'h0000_0004, 32'h0000_0008};
      t_exp   = '{32'hFFFF_FF80, 32'h0000_00F3, 32'hFFFF_FF85, 32'hFFFF_8001,
                  32'h0000_9ABC, 32'hDEAD_BEEF, 32'hCAFE_F00D};
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         lsu_en = 1'b1; lsu_op = 1'b0; lsu_size = t_size[i]; lsu_uns = t_uns[i];
         lsu_addr = t_addr[i]; gnt = 1'b1;
         @(negedge clk);
         lsu_en = 1'b0;
         n_cmp++;
         if ({req, be, daddr} !== {1'b1, t_be[i], t_daddr[i]}) begin
            $display("FAIL load_req[%0d] req=%b be=%b addr=%h want 1 %b %h",
                     i, req, be, daddr, t_be[i], t_daddr[i]);
            n_err++;
         end
         @(negedge clk);
         gnt = 1'b0; rvalid = 1'b1; drdata = t_raw[i];
         @(negedge clk);
         rvalid = 1'b0;
         n_cmp++;
         if ({busy, rdata_o} !== {1'b0, t_exp[i]}) begin
            $display("FAIL load_data[%0d] busy=%b rdata=%h want 0 %h", i, busy, rdata_o, t_exp[i]);
            n_err++;
         end
      end
   endtask

   task automatic test_fault();
      @(negedge clk);
      lsu_en = 1'b1; lsu_op = 1'b0; lsu_size = 2'b01; lsu_uns = 1'b1;
      lsu_addr = 32'h0000_0002; gnt = 1'b1;
      @(negedge clk);
      lsu_en = 1'b0;
      @(negedge clk);
      gnt = 1'b0; rvalid = 1'b1; err = 1'b1; drdata = 32'h1234_5678;
      @(negedge clk);
      rvalid = 1'b0; err = 1'b0;
      n_cmp++;
      if ({fault, busy, rdata_o} !== {1'b1, 1'b0, 32'hCAFE_F00D}) begin
         $display("FAIL fault_pulse fault=%b busy=%b rdata=%h want 1 0 cafef00d", fault, busy, rdata_o);
         n_err++;
      end
      @(negedge clk);
      n_cmp++;
      if (fault !== 1'b0) begin
         $display("FAIL fault_clear got %b want 0", fault);
         n_err++;
      end
   endtask

   task automatic test_en_held();
      int nreq;
      nreq = 0;
      @(negedge clk);
      lsu_en = 1'b1; lsu_op = 1'b0; lsu_size = 2'b10; lsu_uns = 1'b0;
      lsu_addr = 32'h0000_0010; gnt = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (req) nreq++;
         if (busy && !req) begin
            rvalid = 1'b1; drdata = 32'h1357_9BDF;
         end else begin
            rvalid = 1'b0;
         end
      end
      rvalid = 1'b0;
      n_cmp++;
      if (nreq !== 1) begin
         $display("FAIL en_held_count got %0d requests want 1", nreq);
         n_err++;
      end
      n_cmp++;
      if (rdata_o !== 32'h1357_9BDF) begin
         $display("FAIL en_held_data got %h want 13579bdf", rdata_o);
         n_err++;
      end
      lsu_en = 1'b0;
      @(negedge clk);
      lsu_en = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (req !== 1'b1) begin
         $display("FAIL en_rearm_req got %b want 1", req);
         n_err++;
      end
      lsu_en = 1'b0;
      @(negedge clk);
      gnt = 1'b0; rvalid = 1'b1; drdata = 32'h1357_9BDF;
      @(negedge clk);
      rvalid = 1'b0;
   endtask

   task automatic test_reset_in_wait();
      @(negedge clk);
      lsu_en = 1'b1; lsu_op = 1'b0; lsu_size = 2'b10; lsu_addr = 32'h0000_0020; gnt = 1'b1;
      @(negedge clk);
      lsu_en = 1'b0;
      @(negedge clk);
      gnt = 1'b0;
      n_cmp++;
      if ({busy, req} !== 2'b10) begin
         $display("FAIL rst_wait_pre busy/req got %b want 10", {busy, req});
         n_err++;
      end
      #2 rstn = 1'b0;
      #1;
      n_cmp++;
      if ({busy, req, be, rdata_o} !== {2'b00, 4'b0000, 32'h0}) begin
         $display("FAIL rst_wait_async busy=%b req=%b be=%b rdata=%h want 0 0 0000 0",
                  busy, req, be, rdata_o);
         n_err++;
      end
      @(negedge clk);
      rstn = 1'b1; rvalid = 1'b1; err = 1'b1; drdata = 32'hFFFF_0000; lsu_en = 1'b1;
      @(negedge clk);
      rvalid = 1'b0; err = 1'b0;
      n_cmp++;
      if ({fault, busy, req, rdata_o} !== {3'b000, 32'h0}) begin
         $display("FAIL rst_stray_rvalid fault/busy/req=%b rdata=%h want 000 0",
                  {fault, busy, req}, rdata_o);
         n_err++;
      end
      @(negedge clk);
      n_cmp++;
      if (req !== 1'b0) begin
         $display("FAIL rst_unarmed req got %b want 0", req);
         n_err++;
      end
      lsu_en = 1'b0;
      @(negedge clk);
      lsu_en = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (req !== 1'b1) begin
         $display("FAIL rst_rearm req got %b want 1", req);
         n_err++;
      end
      lsu_en = 1'b0; gnt = 1'b1;
      @(negedge clk);
      gnt = 1'b0; rvalid = 1'b1; drdata = 32'h0000_00A5;
      @(negedge clk);
      rvalid = 1'b0;
      n_cmp++;
      if (rdata_o !== 32'h0000_00A5) begin
         $display("FAIL rst_after_load got %h want 000000a5", rdata_o);
         n_err++;
      end
   endtask

   initial begin
      rstn = 1'b0; lsu_en = 1'b0; lsu_op = 1'b0; lsu_size = 2'b00; lsu_uns = 1'b0;
      lsu_addr = 32'h0; lsu_wdata = 32'h0; gnt = 1'b0; rvalid = 1'b0; err = 1'b0;
      drdata = 32'h0;
      test_reset();
      test_byte_load();
      test_half_store();
      test_misaligned();
      test_loads();
      test_fault();
      test_en_held();
      test_reset_in_wait();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
